// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg
// EX/MEM pipeline boundary with a valid/ready handshake and a 2-entry skid
// buffer (main register M plus skid register S). in_ready comes straight from
// a flop, so MEM stalls never create a combinational ready path back into EX.
// Outputs are taken from M only. An empty M always holds the NOP bubble
// encoding, so MEM can ignore out_valid and still see a harmless NOP.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   flush                      drop every held entry (mispredict / trap)
//   in_valid / in_ready        EX-side handshake (in_ready registered)
//   in_target .. in_op3        instruction fields from EX
//   out_valid / out_ready      MEM-side handshake
//   out_target .. out_op3      entry presented to MEM
module ex_mem_skid_reg #(
  parameter int          TARGET_W = 64,
  parameter int          DATA_W   = 32,
  parameter int          REG_W    = 5,
  parameter logic [1:0]  NOP_OP   = 2'b00,
  parameter logic [2:0]  NOP_OP2  = 3'b100,
  parameter logic [5:0]  NOP_OP3  = 6'b000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [TARGET_W-1:0] in_target,
  input  logic                in_mux_sel,
  input  logic [REG_W-1:0]    in_regD,
  input  logic [DATA_W-1:0]   in_alures,
  input  logic [1:0]          in_op,
  input  logic [2:0]          in_op2,
  input  logic [5:0]          in_op3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TARGET_W-1:0] out_target,
  output logic                out_mux_sel,
  output logic [REG_W-1:0]    out_regD,
  output logic [DATA_W-1:0]   out_alures,
  output logic [1:0]          out_op,
  output logic [2:0]          out_op2,
  output logic [5:0]          out_op3
);

  localparam int ENT_W  = TARGET_W + 1 + REG_W + DATA_W + 2 + 3 + 6;
  localparam int ZERO_W = TARGET_W + 1 + REG_W + DATA_W;
  localparam logic [ENT_W-1:0] NOP_ENT = {{ZERO_W{1'b0}}, NOP_OP, NOP_OP2, NOP_OP3};

  logic [ENT_W-1:0] m_q, m_d;
  logic [ENT_W-1:0] s_q, s_d;
  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [ENT_W-1:0] in_ent;
  logic             acc, pop;

  assign in_ent = {in_target, in_mux_sel, in_regD, in_alures, in_op, in_op2, in_op3};
  assign acc    = in_valid && in_ready_q;
  assign pop    = m_valid_q && out_ready;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_d       = NOP_ENT;
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || pop) begin
      if (s_valid_q) begin
        // in_ready is low whenever S is full, so no acc can collide here
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (acc) begin
        m_d       = in_ent;
        m_valid_d = 1'b1;
      end else begin
        m_d       = NOP_ENT;
        m_valid_d = 1'b0;
      end
    end else if (acc) begin
      s_d       = in_ent;
      s_valid_d = 1'b1;
    end
    in_ready_d = !s_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q        <= NOP_ENT;
      s_q        <= NOP_ENT;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  assign {out_target, out_mux_sel, out_regD, out_alures, out_op, out_op2, out_op3} = m_q;

endmodule
